// File: rtl/bcd_2dig_to_bin_if.sv
// bcd_2dig_to_bin_if: start/digit request and result/handshake bundle for bcd_2dig_to_bin.
interface bcd_2dig_to_bin_if;
    logic       start;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic [6:0] bin_out;
    logic       busy;
    logic       done;
    logic       err;
    modport master (output start, digit1, digit0, input bin_out, busy, done, err);
    modport slave  (input start, digit1, digit0, output bin_out, busy, done, err);
endinterface

// File: rtl/bcd_2dig_to_bin.sv
// bcd_2dig_to_bin: two-digit BCD to 7-bit binary via reverse double-dabble, start/busy/done handshake.
// Optional BCD_RANGE_CHECK_EN flags digits above 9 with err and a short-circuit result of 0.
module bcd_2dig_to_bin (
    input logic          clk,
    input logic          reset,
    bcd_2dig_to_bin_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic       start_reg, start_tick, last, bad, err_reg;
    logic [7:0] bcd, bcd_nxt;
    logic [6:0] bin, bin_nxt;
    logic [2:0] cnt;

    function automatic logic [3:0] fix(input logic [3:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

    assign start_tick = bus.start & ~start_reg;
    assign last       = cnt == 3'd6;

    // One right shift of {bcd, bin} followed by the per-nibble -3 correction
    always_comb begin
        bin_nxt = {bcd[0], bin[6:1]};
        bcd_nxt = {fix({1'b0, bcd[7:5]}), fix(bcd[4:1])};
    end

`ifdef BCD_RANGE_CHECK_EN
    assign bad     = (bus.digit1 > 4'd9) | (bus.digit0 > 4'd9);
    assign bus.err = (state == DONE) & err_reg;
`else
    assign bad     = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        state_nxt = (state == IDLE)  ? (start_tick ? SHIFT : IDLE) :
                    (state == SHIFT) ? ((last | err_reg) ? DONE : SHIFT) : IDLE;
        bus.busy  = state != IDLE;
        bus.done  = state == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_reg   <= 1'b0;
            bcd         <= '0;
            bin         <= '0;
            cnt         <= '0;
            err_reg     <= 1'b0;
            bus.bin_out <= '0;
        end else begin
            start_reg <= bus.start;
            if (state == IDLE && start_tick) begin
                bcd     <= {bus.digit1, bus.digit0};
                bin     <= '0;
                cnt     <= '0;
                err_reg <= bad;
            end else if (state == SHIFT) begin
                bcd <= bcd_nxt;
                bin <= bin_nxt;
                cnt <= cnt + 3'd1;
                if (err_reg)   bus.bin_out <= '0;
                else if (last) bus.bin_out <= bin_nxt;
            end
        end
    end
endmodule

// File: tb/tb_bcd_2dig_to_bin.sv
// tb_bcd_2dig_to_bin: randomized self-checking bench; reference result is digit1*10 + digit0.
module tb_bcd_2dig_to_bin;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    bcd_2dig_to_bin_if bus ();
    bcd_2dig_to_bin dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Drives one request from an idle DUT and observes 12 cycles after the accepting edge
    task automatic run_conv(input logic [3:0] a, input logic [3:0] b, output int lat,
                            output logic [6:0] bo, output logic e, output int nbusy, output int ndone);
        lat = -1; bo = 'x; e = 'x; ndone = 0;
        bus.digit1 = a; bus.digit0 = b; bus.start = 1'b1;
        @(posedge clk); #1;
        nbusy = bus.busy ? 1 : 0;
        bus.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin lat = i; bo = bus.bin_out; e = bus.err; end
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.digit1 = 4'd0; bus.digit0 = 4'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({bus.bin_out, bus.busy, bus.done, bus.err} !== 10'd0) begin
            fails++; $display("FAIL reset_state got=%b want=0", {bus.bin_out, bus.busy, bus.done, bus.err});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        int lat, nb, nd; logic [6:0] bo; logic e;
        run_conv(4'd9, 4'd9, lat, bo, e, nb, nd);
        tests++; if (lat != 7)   begin fails++; $display("FAIL max_latency got=%0d want=7", lat); end
        tests++; if (nb != 8)    begin fails++; $display("FAIL max_busy_cycles got=%0d want=8", nb); end
        tests++; if (nd != 1)    begin fails++; $display("FAIL max_done_count got=%0d want=1", nd); end
        tests++; if (bo !== 7'd99) begin fails++; $display("FAIL max_bin got=%0d want=99", bo); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL max_err got=%b want=0", e); end
    endtask

    task automatic test_sweep();
        int order[100];
        int lat, nb, nd, j, t, bad_cnt;
        logic [6:0] bo; logic e;
        for (int i = 0; i < 100; i++) order[i] = i;
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(i, 0); t = order[i]; order[i] = order[j]; order[j] = t;
        end
        bad_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            logic [3:0] a, b;
            a = 4'(order[i] / 10); b = 4'(order[i] % 10);
            run_conv(a, b, lat, bo, e, nb, nd);
            tests++;
            if (bo !== 7'(a * 10 + b) || lat != 7 || nd != 1 || e !== 1'b0) begin
                fails++;
                $display("FAIL sweep_%0d%0d got bin=%0d lat=%0d done=%0d err=%b want bin=%0d lat=7 done=1 err=0",
                         a, b, bo, lat, nd, e, a * 10 + b);
            end
        end
    endtask

    task automatic test_hold_and_toggle();
        int nd;
        bus.digit1 = 4'd1; bus.digit0 = 4'd0; bus.start = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        bus.start = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (bus.done) nd++; end
        tests++; if (nd != 1) begin fails++; $display("FAIL hold_done_count got=%0d want=1", nd); end
        tests++; if (bus.bin_out !== 7'd10) begin fails++; $display("FAIL hold_bin got=%0d want=10", bus.bin_out); end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.digit1 = 4'd4; bus.digit0 = 4'd2;
        nd = 0;
        for (int i = 1; i < 20; i++) begin
            bus.start = (i >= 2 && i <= 6) ? ~bus.start : 1'b0;
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        tests++; if (nd != 1) begin fails++; $display("FAIL toggle_done_count got=%0d want=1", nd); end
        tests++; if (bus.bin_out !== 7'd10) begin fails++; $display("FAIL toggle_bin got=%0d want=10", bus.bin_out); end
    endtask

    task automatic test_reset_abort();
        int lat, nb, nd; logic [6:0] bo; logic e;
        run_conv(4'd5, 4'd7, lat, bo, e, nb, nd);
        tests++; if (bo !== 7'd57) begin fails++; $display("FAIL abort_pre_bin got=%0d want=57", bo); end
        bus.digit1 = 4'd2; bus.digit0 = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.bin_out, bus.busy} !== 8'd0) begin
            fails++; $display("FAIL abort_state got bin=%0d busy=%b want 0 0", bus.bin_out, bus.busy);
        end
        nd = 0;
        repeat (3) begin @(posedge clk); #1; if (bus.done) nd++; end
        reset = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (bus.done) nd++; end
        tests++; if (nd != 0) begin fails++; $display("FAIL abort_done_count got=%0d want=0", nd); end
        tests++; if (bus.bin_out !== 7'd0) begin fails++; $display("FAIL abort_bin got=%0d want=0", bus.bin_out); end
        run_conv(4'd2, 4'd3, lat, bo, e, nb, nd);
        tests++; if (bo !== 7'd23 || lat != 7) begin fails++; $display("FAIL abort_redo got bin=%0d lat=%0d want 23 7", bo, lat); end
    endtask

    task automatic test_invalid();
        int lat, nb, nd; logic [6:0] bo; logic e;
        run_conv(4'hA, 4'd5, lat, bo, e, nb, nd);
`ifdef BCD_RANGE_CHECK_EN
        tests++; if (lat != 1)     begin fails++; $display("FAIL invalid_latency got=%0d want=1", lat); end
        tests++; if (e !== 1'b1)   begin fails++; $display("FAIL invalid_err got=%b want=1", e); end
        tests++; if (bo !== 7'd0)  begin fails++; $display("FAIL invalid_bin got=%0d want=0", bo); end
`else
        tests++; if (lat != 7)     begin fails++; $display("FAIL invalid_latency got=%0d want=7", lat); end
        tests++; if (e !== 1'b0)   begin fails++; $display("FAIL invalid_err got=%b want=0", e); end
`endif
        tests++; if (nd != 1)      begin fails++; $display("FAIL invalid_done_count got=%0d want=1", nd); end
        run_conv(4'd0, 4'd0, lat, bo, e, nb, nd);
        tests++;
        if (bo !== 7'd0 || e !== 1'b0 || lat != 7) begin
            fails++; $display("FAIL zero_after_invalid got bin=%0d err=%b lat=%0d want 0 0 7", bo, e, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb, nd; logic [6:0] bo; logic e;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom_range(9, 0)); b = 4'($urandom_range(9, 0));
            run_conv(a, b, lat, bo, e, nb, nd);
            tests++;
            if (bo !== 7'(a * 10 + b) || nb != 8 || nd != 1) begin
                fails++;
                $display("FAIL b2b_%0d%0d got bin=%0d busy=%0d done=%0d want bin=%0d busy=8 done=1",
                         a, b, bo, nb, nd, a * 10 + b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_sweep();
        test_hold_and_toggle();
        test_reset_abort();
        test_invalid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
